// File: rtl/nearest_hit_pkg.sv
// nearest_hit_reduce shared types and helpers.
// FSM encoding, empty-record value and the hit update rule.
package nearest_hit_pkg;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  localparam logic signed [31:0] T_MAX = 32'sh7FFF_FFFF;

  // A candidate replaces the current best only if it is a valid hit
  // and strictly nearer, so ties keep the earlier index.
  function automatic logic hit_better(
    input logic signed [31:0] t,
    input logic signed [31:0] eps,
    input logic signed [31:0] best_t,
    input logic               best_hit
  );
    return (t > eps) && (!best_hit || (t < best_t));
  endfunction

endpackage

// File: rtl/nearest_hit_reduce.sv
// Nearest valid hit reduction over fixed-size candidate groups.
// Pops N_ITEMS t values, emits one {t, idx, hit} record per group.
module nearest_hit_reduce
  import nearest_hit_pkg::*;
#(
  parameter int               Q_BITS  = 16,
  parameter int               N_ITEMS = 16,
  parameter int               IDX_W   = $clog2(N_ITEMS),
  parameter logic signed [31:0] EPS   = 32'sd64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [31:0]      in_dout,
  input  logic                    in_empty,
  output logic                    in_rd_en,
  output logic signed [31:0]      out_t,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_hit,
  input  logic                    out_full,
  output logic                    out_wr_en
);

  if (N_ITEMS < 2 || Q_BITS < 0 || Q_BITS > 31) begin : g_bad_param
    $error("nearest_hit_reduce: unsupported N_ITEMS or Q_BITS");
  end

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITEMS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic signed [31:0] best_t_q, best_t_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               best_hit_q, best_hit_d;

  assign out_t   = best_t_q;
  assign out_idx = best_idx_q;
  assign out_hit = best_hit_q;

  // State and running-best registers; reset discards any partial group.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_READ;
      cnt_q      <= '0;
      best_t_q   <= T_MAX;
      best_idx_q <= '0;
      best_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_t_q   <= best_t_d;
      best_idx_q <= best_idx_d;
      best_hit_q <= best_hit_d;
    end
  end

  // Pop/compare while reading, then hold the record until it is written.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_t_d   = best_t_q;
    best_idx_d = best_idx_q;
    best_hit_d = best_hit_q;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    unique case (state_q)
      S_READ: begin
        in_rd_en = !in_empty;
        if (!in_empty) begin
          if (hit_better(in_dout, EPS, best_t_q, best_hit_q)) begin
            best_t_d   = in_dout;
            best_idx_d = cnt_q;
            best_hit_d = 1'b1;
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        out_wr_en = !out_full;
        if (!out_full) begin
          best_t_d   = T_MAX;
          best_idx_d = '0;
          best_hit_d = 1'b0;
          state_d    = S_READ;
        end
      end
      default: begin
        state_d = S_READ;
      end
    endcase
  end

endmodule

// File: tb/tb_nearest_hit_reduce.sv
// Directed bench for nearest_hit_reduce, N_ITEMS=4, EPS=64.
// Hand-computed records, backpressure, gaps and mid-group reset.
module tb_nearest_hit_reduce;

  localparam int N     = 4;
  localparam int IW    = 2;
  localparam logic [31:0] TMAX = 32'h7FFF_FFFF;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] in_dout = '0;
  logic               in_empty = 1'b1;
  logic               in_rd_en;
  logic signed [31:0] out_t;
  logic [IW-1:0]      out_idx;
  logic               out_hit;
  logic               out_full = 1'b0;
  logic               out_wr_en;

  int nvec = 0;
  int nerr = 0;
  int nwr  = 0;

  always #5 clock = ~clock;

  nearest_hit_reduce #(
    .Q_BITS (16),
    .N_ITEMS(N),
    .EPS    (32'sd64)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .out_t    (out_t),
    .out_idx  (out_idx),
    .out_hit  (out_hit),
    .out_full (out_full),
    .out_wr_en(out_wr_en)
  );

  always @(posedge clock)
    if (!reset && out_wr_en) nwr++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts just after a posedge; pops one value on the next posedge.
  task automatic pop(input logic [31:0] v);
    in_dout  = v;
    in_empty = 1'b0;
    @(negedge clock);
    chk("rd_en_pop", 32'(in_rd_en), 32'd1);
    chk("wr_en_pop", 32'(out_wr_en), 32'd0);
    @(posedge clock);
    #1;
    in_empty = 1'b1;
  endtask

  task automatic idle_cycle();
    in_empty = 1'b1;
    @(negedge clock);
    chk("rd_en_gap", 32'(in_rd_en), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic finish_group(input string tag,
                              input logic [31:0] et,
                              input logic [31:0] ei,
                              input logic [31:0] eh);
    in_dout  = 32'h1234_5678;
    in_empty = 1'b0;
    @(negedge clock);
    chk({tag, "_wr"},  32'(out_wr_en), 32'd1);
    chk({tag, "_rd"},  32'(in_rd_en), 32'd0);
    chk({tag, "_t"},   out_t, et);
    chk({tag, "_idx"}, 32'(out_idx), ei);
    chk({tag, "_hit"}, 32'(out_hit), eh);
    @(posedge clock);
    #1;
    in_empty = 1'b1;
    @(negedge clock);
    chk({tag, "_clr_hit"}, 32'(out_hit), 32'd0);
    chk({tag, "_clr_t"},   out_t, TMAX);
    chk({tag, "_clr_wr"},  32'(out_wr_en), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_empty = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_t",   out_t, TMAX);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_hit", 32'(out_hit), 32'd0);
    chk("rst_rd",  32'(in_rd_en), 32'd0);
    chk("rst_wr",  32'(out_wr_en), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 5.0, 2.0, -1.0, 3.0 -> 2.0 at idx 1
    pop(32'h0005_0000);
    pop(32'h0002_0000);
    pop(32'hFFFF_0000);
    pop(32'h0003_0000);
    finish_group("g1", 32'h0002_0000, 32'd1, 32'd1);

    // nothing above EPS -> miss record
    pop(32'h0000_0000);
    pop(32'hFFFF_FFFB);
    pop(32'h0000_0040);
    pop(32'hFFFF_FFFF);
    finish_group("g2", TMAX, 32'd0, 32'd0);

    // EPS boundary: 64 rejected, 65 accepted
    pop(32'h0000_0040);
    pop(32'h0000_0041);
    pop(32'h0001_0000);
    pop(32'h0000_0064);
    finish_group("g2b", 32'h0000_0041, 32'd1, 32'd1);

    // ties keep the earliest index
    pop(32'h0001_0000);
    pop(32'h0001_0000);
    pop(32'h0004_0000);
    pop(32'h0001_0000);
    finish_group("g3", 32'h0001_0000, 32'd0, 32'd1);

    // backpressure for 10 cycles on the record
    out_full = 1'b1;
    pop(32'h0009_0000);
    pop(32'h0008_0000);
    pop(32'h0007_0000);
    pop(32'h0010_0000);
    in_dout  = 32'h0000_1000;
    in_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_wr",  32'(out_wr_en), 32'd0);
      chk("bp_rd",  32'(in_rd_en), 32'd0);
      chk("bp_t",   out_t, 32'h0007_0000);
      chk("bp_idx", 32'(out_idx), 32'd2);
      chk("bp_hit", 32'(out_hit), 32'd1);
      @(posedge clock);
      #1;
    end
    out_full = 1'b0;
    finish_group("g4", 32'h0007_0000, 32'd2, 32'd1);

    // best must restart from cleared values after the stalled write
    pop(32'h000A_0000);
    pop(32'h000B_0000);
    pop(32'h000C_0000);
    pop(32'h000D_0000);
    finish_group("g5", 32'h000A_0000, 32'd0, 32'd1);

    // group 1 again with an empty cycle before every pop
    idle_cycle(); pop(32'h0005_0000);
    idle_cycle(); pop(32'h0002_0000);
    idle_cycle(); pop(32'hFFFF_0000);
    idle_cycle(); pop(32'h0003_0000);
    finish_group("g6", 32'h0002_0000, 32'd1, 32'd1);

    // reset after two pops discards the partial group
    pop(32'h0000_0080);
    pop(32'h0002_0000);
    reset    = 1'b1;
    in_empty = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("mr_hit", 32'(out_hit), 32'd0);
    chk("mr_t",   out_t, TMAX);
    chk("mr_wr",  32'(out_wr_en), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    pop(32'h0004_0000);
    pop(32'h0005_0000);
    pop(32'h0006_0000);
    pop(32'h0000_1000);
    finish_group("g7", 32'h0000_1000, 32'd3, 32'd1);

    repeat (3) @(posedge clock);
    chk("write_count", 32'(nwr), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
